adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The module SHALL have parameter FAIR, default 1. FAIR=1 selects round-robin arbitration; FAIR=0 selects fixed priority, with requester 0 highest.
REQ-002 Clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Reset_n  input  1  reset, synchronous and active-low.
REQ-004 Req0_Valid  input  1  requester 0 has an add request pending.
REQ-005 Req0_A, Req0_B  input  16 each  requester 0 unsigned operands.
REQ-006 Req0_Ready  output  1  request 0 accepted this cycle.
REQ-007 Req1_Valid, Req1_A, Req1_B, Req1_Ready  same widths/meaning as REQ-004..006, for requester 1.
REQ-008 Resp0_Valid  output  1  result for requester 0 available.
REQ-009 Resp0_Sum  output  16  sum result for requester 0.
REQ-010 Resp0_CO  output  1  carry-out result for requester 0.
REQ-011 Resp0_Ready  input  1  requester 0 takes the result.
REQ-012 Resp1_Valid, Resp1_Sum, Resp1_CO, Resp1_Ready  same as REQ-008..011, for requester 1.
REQ-013 Busy  output  1  FSM not in IDLE.
REQ-014 Last_Grant  output  1  index of the most recently granted requester.

Function
REQ-015 One shared 16-bit combinational adder instance SHALL be used: inputs A, B; outputs Sum, CO; carry-in fixed 0. No second adder is permitted.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-017 IDLE: if any Req*_Valid is high, the FSM SHALL grant exactly one requester.
  - Grant selection per REQ-018.
  - Granted Req*_Ready asserted combinationally in the same cycle.
  - Operands captured into internal registers; grant index recorded.
  - Next state EXEC.
  - If no Req*_Valid is high, remain in IDLE.
REQ-018 Both valid, FAIR=1: grant the requester not equal to Last_Grant. Both valid, FAIR=0: grant requester 0. Only one valid: grant that requester.
REQ-019 Req*_Ready SHALL be 0 in EXEC and RESP, and 0 for the non-granted requester in IDLE.
REQ-020 EXEC: the adder SHALL be driven only from the captured operand registers. Sum/CO are registered into the granted requester's response registers; that Resp*_Valid is set; next state RESP.
REQ-021 RESP: hold while the granted Resp*_Ready is 0. When Resp*_Ready=1, clear that Resp*_Valid at the clock edge and go to IDLE.
REQ-022 Latency: request accepted at edge T, Resp*_Valid high from T+2. Minimum issue interval SHALL be 3 cycles.
REQ-023 Resp*_Sum/CO SHALL stay stable while Resp*_Valid is high. They retain their last value after the handshake.
REQ-024 The non-granted requester's response outputs SHALL be unaffected by a transaction.
REQ-025 Operand changes on Req*_A/B after acceptance SHALL NOT affect the result.
REQ-026 Arithmetic: {CO,Sum} = A + B modulo 2^17, unsigned. Overflow wraps Sum; CO=1 on overflow.
REQ-027 Last_Grant SHALL update at each acceptance edge and hold otherwise.
REQ-028 A Req*_Valid that drops before grant SHALL be ignored, with no state change.
REQ-029 Resp*_Ready asserted while the corresponding Resp*_Valid=0 SHALL have no effect.

Reset
REQ-030 Reset_n=0 at a clock edge SHALL force the following, regardless of state:
  - state=IDLE
  - Resp0_Valid=Resp1_Valid=0
  - Resp0_Sum=Resp1_Sum=0
  - Resp0_CO=Resp1_CO=0
  - Last_Grant=1, so requester 0 wins the first FAIR=1 contention
  - operand registers=0
REQ-031 While Reset_n=0: Req0_Ready=Req1_Ready=0 and Busy=0.
REQ-032 Reset mid-transaction SHALL discard the in-flight operation with no response issued.

Verification
REQ-033 Single request: Req0 A=0x1234, B=0x0F0F -> Req0_Ready=1 at T; Resp0_Valid at T+2 with Sum=0x2143, CO=0.
REQ-034 Overflow: Req1 A=0xFFFF, B=0x0001 -> Resp1_Sum=0x0000, Resp1_CO=1; Resp0_Valid stays 0.
REQ-035 Contention, FAIR=1: both valid continuously after reset -> grants 0,1,0,1; each accept 3 cycles apart with Resp*_Ready tied high.
REQ-036 Backpressure: Resp0_Ready=0 for 5 cycles -> Resp0_Valid and Sum stable; Busy=1; Req1_Ready stays 0 throughout; Req1 is accepted the cycle after the handshake.
REQ-037 Reset mid-op: Reset_n=0 in EXEC -> next cycle all outputs 0 (Last_Grant=1), no response, Busy=0.
REQ-038 Operand hold: Req0_A changes at T+1 -> result reflects operands captured at T.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share a single 16-bit adder through an
// IDLE -> EXEC -> RESP handshake FSM, with round-robin or fixed-priority grant.

// Shared combinational adder; carry-in is tied to zero.
module adder_arbiter_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        co
);
    assign {co, sum} = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter #(
    parameter int unsigned FAIR = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req0_Valid,
    input  logic [15:0] Req0_A,
    input  logic [15:0] Req0_B,
    output logic        Req0_Ready,
    input  logic        Req1_Valid,
    input  logic [15:0] Req1_A,
    input  logic [15:0] Req1_B,
    output logic        Req1_Ready,
    output logic        Resp0_Valid,
    output logic [15:0] Resp0_Sum,
    output logic        Resp0_CO,
    input  logic        Resp0_Ready,
    output logic        Resp1_Valid,
    output logic [15:0] Resp1_Sum,
    output logic        Resp1_CO,
    input  logic        Resp1_Ready,
    output logic        Busy,
    output logic        Last_Grant
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        grant_idx;
    logic        last_grant;

    logic        valid0;
    logic [15:0] sum0;
    logic        co0;
    logic        valid1;
    logic [15:0] sum1;
    logic        co1;

    logic        grant_any;
    logic        grant_sel;
    logic [15:0] add_sum;
    logic        add_co;

    // The adder only ever sees the captured operands, never the live request buses.
    adder_arbiter_add16 u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum),
        .co  (add_co)
    );

    // Next-state, grant selection and request-ready generation.
    always_comb begin
        state_next = state;
        grant_any  = 1'b0;
        grant_sel  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Req0_Valid || Req1_Valid) begin
                    grant_any  = 1'b1;
                    state_next = EXEC;
                    if (Req0_Valid && Req1_Valid) begin
                        grant_sel = (FAIR != 0) ? ~last_grant : 1'b0;
                    end else begin
                        grant_sel = Req1_Valid;
                    end
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (grant_idx ? Resp1_Ready : Resp0_Ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Readies are masked by reset since the state register only clears on the edge.
        Req0_Ready = Reset_n && grant_any && !grant_sel;
        Req1_Ready = Reset_n && grant_any &&  grant_sel;
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, grant bookkeeping and per-requester response registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            op_a       <= '0;
            op_b       <= '0;
            grant_idx  <= 1'b0;
            last_grant <= 1'b1;
            valid0     <= 1'b0;
            sum0       <= '0;
            co0        <= 1'b0;
            valid1     <= 1'b0;
            sum1       <= '0;
            co1        <= 1'b0;
        end else begin
            if (state == IDLE && grant_any) begin
                op_a       <= grant_sel ? Req1_A : Req0_A;
                op_b       <= grant_sel ? Req1_B : Req0_B;
                grant_idx  <= grant_sel;
                last_grant <= grant_sel;
            end
            if (state == EXEC) begin
                if (grant_idx) begin
                    valid1 <= 1'b1;
                    sum1   <= add_sum;
                    co1    <= add_co;
                end else begin
                    valid0 <= 1'b1;
                    sum0   <= add_sum;
                    co0    <= add_co;
                end
            end
            if (state == RESP) begin
                if (grant_idx && Resp1_Ready) begin
                    valid1 <= 1'b0;
                end
                if (!grant_idx && Resp0_Ready) begin
                    valid0 <= 1'b0;
                end
            end
        end
    end

    assign Busy        = Reset_n && (state != IDLE);
    assign Last_Grant  = last_grant;
    assign Resp0_Valid = valid0;
    assign Resp0_Sum   = sum0;
    assign Resp0_CO    = co0;
    assign Resp1_Valid = valid1;
    assign Resp1_Sum   = sum1;
    assign Resp1_CO    = co1;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter: round-robin instance plus a
// fixed-priority instance sharing the same stimulus.
module tb_adder_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Req0_Valid, Req1_Valid;
    logic [15:0] Req0_A, Req0_B, Req1_A, Req1_B;
    logic        Resp0_Ready, Resp1_Ready;

    logic        Req0_Ready, Req1_Ready;
    logic        Resp0_Valid, Resp1_Valid;
    logic [15:0] Resp0_Sum, Resp1_Sum;
    logic        Resp0_CO, Resp1_CO;
    logic        Busy, Last_Grant;

    logic        f_Req0_Ready, f_Req1_Ready;
    logic        f_Resp0_Valid, f_Resp1_Valid;
    logic [15:0] f_Resp0_Sum, f_Resp1_Sum;
    logic        f_Resp0_CO, f_Resp1_CO;
    logic        f_Busy, f_Last_Grant;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    adder_arbiter #(.FAIR(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0_Valid(Req0_Valid), .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Ready(Req0_Ready),
        .Req1_Valid(Req1_Valid), .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Ready(Req1_Ready),
        .Resp0_Valid(Resp0_Valid), .Resp0_Sum(Resp0_Sum), .Resp0_CO(Resp0_CO), .Resp0_Ready(Resp0_Ready),
        .Resp1_Valid(Resp1_Valid), .Resp1_Sum(Resp1_Sum), .Resp1_CO(Resp1_CO), .Resp1_Ready(Resp1_Ready),
        .Busy(Busy), .Last_Grant(Last_Grant)
    );

    adder_arbiter #(.FAIR(0)) u_fix (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0_Valid(Req0_Valid), .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Ready(f_Req0_Ready),
        .Req1_Valid(Req1_Valid), .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Ready(f_Req1_Ready),
        .Resp0_Valid(f_Resp0_Valid), .Resp0_Sum(f_Resp0_Sum), .Resp0_CO(f_Resp0_CO), .Resp0_Ready(Resp0_Ready),
        .Resp1_Valid(f_Resp1_Valid), .Resp1_Sum(f_Resp1_Sum), .Resp1_CO(f_Resp1_CO), .Resp1_Ready(Resp1_Ready),
        .Busy(f_Busy), .Last_Grant(f_Last_Grant)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        Req0_Valid = 1'b1; Req0_A = '0; Req0_B = '0;
        Req1_Valid = 1'b0; Req1_A = '0; Req1_B = '0;
        Resp0_Ready = 1'b0; Resp1_Ready = 1'b0;

        // Reset state, with a request held during reset
        tick(); tick();
        settle();
        check("rst_ready0", Req0_Ready, 0);
        check("rst_busy", Busy, 0);
        check("rst_valid0", Resp0_Valid, 0);
        check("rst_valid1", Resp1_Valid, 0);
        check("rst_sum0", Resp0_Sum, 0);
        check("rst_sum1", Resp1_Sum, 0);
        check("rst_co0", Resp0_CO, 0);
        check("rst_co1", Resp1_CO, 0);
        check("rst_last", Last_Grant, 1);
        tick();
        Reset_n = 1'b1; Req0_Valid = 1'b0;
        tick();

        // Response ready with no valid response does nothing
        Resp0_Ready = 1'b1; Resp1_Ready = 1'b1;
        settle();
        check("idle_rdy_busy", Busy, 0);
        check("idle_rdy_valid0", Resp0_Valid, 0);
        tick();
        Resp0_Ready = 1'b0; Resp1_Ready = 1'b0;

        // Single request on port 0; operands change after acceptance
        Req0_Valid = 1'b1; Req0_A = 16'h1234; Req0_B = 16'h0F0F;
        settle();
        check("t1_ready0", Req0_Ready, 1);
        check("t1_ready1", Req1_Ready, 0);
        tick();
        Req0_Valid = 1'b0; Req0_A = 16'hFFFF; Req0_B = 16'hFFFF;
        settle();
        check("t1_exec_busy", Busy, 1);
        check("t1_exec_ready0", Req0_Ready, 0);
        check("t1_exec_valid0", Resp0_Valid, 0);
        tick();
        settle();
        check("t1_valid0", Resp0_Valid, 1);
        check("t1_sum0", Resp0_Sum, 16'h2143);
        check("t1_co0", Resp0_CO, 0);
        check("t1_last", Last_Grant, 0);
        check("t1_valid1", Resp1_Valid, 0);
        Resp0_Ready = 1'b1;
        tick();
        Resp0_Ready = 1'b0;
        settle();
        check("t1_done_valid0", Resp0_Valid, 0);
        check("t1_done_busy", Busy, 0);
        check("t1_hold_sum0", Resp0_Sum, 16'h2143);
        tick();

        // Overflow on port 1; a short port-0 pulse during EXEC is ignored
        Req1_Valid = 1'b1; Req1_A = 16'hFFFF; Req1_B = 16'h0001; Resp1_Ready = 1'b1;
        settle();
        check("t2_ready1", Req1_Ready, 1);
        check("t2_ready0", Req0_Ready, 0);
        tick();
        Req1_Valid = 1'b0; Req0_Valid = 1'b1;
        settle();
        check("t2_exec_ready0", Req0_Ready, 0);
        tick();
        Req0_Valid = 1'b0;
        settle();
        check("t2_valid1", Resp1_Valid, 1);
        check("t2_sum1", Resp1_Sum, 16'h0000);
        check("t2_co1", Resp1_CO, 1);
        check("t2_valid0", Resp0_Valid, 0);
        check("t2_keep_sum0", Resp0_Sum, 16'h2143);
        check("t2_last", Last_Grant, 1);
        tick();
        settle();
        check("t2_done_valid1", Resp1_Valid, 0);
        check("t2_idle_ready0", Req0_Ready, 0);
        tick();
        settle();
        check("t2_idle_busy", Busy, 0);
        tick();

        // Contention after reset: round-robin alternates, fixed priority keeps port 0
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        Req0_Valid = 1'b1; Req0_A = 16'h0100; Req0_B = 16'h0023;
        Req1_Valid = 1'b1; Req1_A = 16'h8000; Req1_B = 16'h8001;
        Resp0_Ready = 1'b1; Resp1_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("c%0d_ready0", k), Req0_Ready, (k % 2 == 0) ? 1 : 0);
            check($sformatf("c%0d_ready1", k), Req1_Ready, (k % 2 == 1) ? 1 : 0);
            check($sformatf("c%0d_fix_ready0", k), f_Req0_Ready, 1);
            check($sformatf("c%0d_fix_ready1", k), f_Req1_Ready, 0);
            tick();
            settle();
            check($sformatf("c%0d_exec_ready", k), Req0_Ready | Req1_Ready, 0);
            tick();
            settle();
            if (k % 2 == 0) begin
                check($sformatf("c%0d_valid0", k), Resp0_Valid, 1);
                check($sformatf("c%0d_sum0", k), Resp0_Sum, 16'h0123);
                check($sformatf("c%0d_co0", k), Resp0_CO, 0);
            end else begin
                check($sformatf("c%0d_valid1", k), Resp1_Valid, 1);
                check($sformatf("c%0d_sum1", k), Resp1_Sum, 16'h0001);
                check($sformatf("c%0d_co1", k), Resp1_CO, 1);
            end
            check($sformatf("c%0d_last", k), Last_Grant, k % 2);
            if (k == 3) begin
                Req0_Valid = 1'b0; Req1_Valid = 1'b0;
            end
            tick();
        end
        check("c_fix_sum0", f_Resp0_Sum, 16'h0123);
        check("c_fix_last", f_Last_Grant, 0);
        check("c_fix_valid1", f_Resp1_Valid, 0);

        // Backpressure on port 0 while port 1 waits
        Req0_Valid = 1'b1; Req0_A = 16'h00FF; Req0_B = 16'h0001;
        Req1_Valid = 1'b1; Req1_A = 16'h4000; Req1_B = 16'h0004;
        Resp0_Ready = 1'b0; Resp1_Ready = 1'b1;
        settle();
        check("bp_ready0", Req0_Ready, 1);
        check("bp_ready1", Req1_Ready, 0);
        tick();
        Req0_Valid = 1'b0;
        settle();
        check("bp_exec_ready1", Req1_Ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("bp%0d_valid0", i), Resp0_Valid, 1);
            check($sformatf("bp%0d_sum0", i), Resp0_Sum, 16'h0100);
            check($sformatf("bp%0d_busy", i), Busy, 1);
            check($sformatf("bp%0d_ready1", i), Req1_Ready, 0);
            tick();
        end
        settle();
        check("bp_hs_ready1", Req1_Ready, 0);
        Resp0_Ready = 1'b1;
        tick();
        Resp0_Ready = 1'b0;
        settle();
        check("bp_after_ready1", Req1_Ready, 1);
        check("bp_after_valid0", Resp0_Valid, 0);
        check("bp_after_sum0", Resp0_Sum, 16'h0100);
        tick();
        Req1_Valid = 1'b0;
        tick();
        settle();
        check("bp_valid1", Resp1_Valid, 1);
        check("bp_sum1", Resp1_Sum, 16'h4004);
        check("bp_co1", Resp1_CO, 0);
        tick();
        settle();
        check("bp_done_valid1", Resp1_Valid, 0);
        tick();

        // Reset while in EXEC discards the operation
        Req0_Valid = 1'b1; Req0_A = 16'h0001; Req0_B = 16'h0002; Resp0_Ready = 1'b1;
        settle();
        check("rm_ready0", Req0_Ready, 1);
        tick();
        Req0_Valid = 1'b0; Reset_n = 1'b0;
        settle();
        check("rm_busy_in_rst", Busy, 0);
        check("rm_ready0_in_rst", Req0_Ready, 0);
        tick();
        Reset_n = 1'b1;
        settle();
        check("rm_valid0", Resp0_Valid, 0);
        check("rm_valid1", Resp1_Valid, 0);
        check("rm_sum0", Resp0_Sum, 0);
        check("rm_sum1", Resp1_Sum, 0);
        check("rm_co0", Resp0_CO, 0);
        check("rm_last", Last_Grant, 1);
        check("rm_busy", Busy, 0);
        tick();
        settle();
        check("rm_no_resp", Resp0_Valid, 0);
        check("rm_idle_busy", Busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
